// File: rtl/md_unit_param_pkg.sv
// Shared definitions for the multiply/divide unit: opcodes, FSM states
// and op-class helpers.
package md_defs;

  typedef enum logic [3:0] {
    OP_MULT  = 4'd0,
    OP_MULTU = 4'd1,
    OP_DIV   = 4'd2,
    OP_DIVU  = 4'd3,
    OP_MADD  = 4'd4,
    OP_MADDU = 4'd5,
    OP_MSUB  = 4'd6,
    OP_MSUBU = 4'd7,
    OP_MTHI  = 4'd8,
    OP_MTLO  = 4'd9,
    OP_NOP   = 4'd15
  } md_op_t;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_RUN  = 1'b1
  } md_state_t;

  function automatic logic is_mult(input md_op_t op);
    return (op == OP_MULT) || (op == OP_MULTU);
  endfunction

  function automatic logic is_div(input md_op_t op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_acc(input md_op_t op);
    return (op == OP_MADD) || (op == OP_MADDU) || (op == OP_MSUB) || (op == OP_MSUBU);
  endfunction

  function automatic logic is_signed_op(input md_op_t op);
    return (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD) || (op == OP_MSUB);
  endfunction

endpackage

// File: rtl/md_unit_param_arith.sv
// Combinational result generator: full-width multiply, multiply-accumulate
// and divide, including the divide-by-zero and MIN/-1 corner cases.
module md_arith
  import md_defs::*;
#(
  parameter int WIDTH = 32
) (
  input  md_op_t           op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] hi,
  input  logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi_n,
  output logic [WIDTH-1:0] lo_n
);

  localparam int W2 = 2 * WIDTH;

  logic             sgn;
  logic [W2-1:0]    a_ext;
  logic [W2-1:0]    b_ext;
  logic [W2-1:0]    prod;
  logic [W2-1:0]    acc;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] b_safe;
  logic [WIDTH-1:0] q_mag;
  logic [WIDTH-1:0] r_mag;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;

  // Signed division works on magnitudes; MIN/-1 falls out naturally as MIN rem 0.
  always_comb begin
    sgn    = is_signed_op(op);
    a_ext  = sgn ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
    b_ext  = sgn ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
    prod   = a_ext * b_ext;
    acc    = ((op == OP_MSUB) || (op == OP_MSUBU)) ? ({hi, lo} - prod) : ({hi, lo} + prod);
    a_neg  = sgn & a[WIDTH-1];
    b_neg  = sgn & b[WIDTH-1];
    a_mag  = a_neg ? -a : a;
    b_mag  = b_neg ? -b : b;
    b_safe = (b_mag == '0) ? WIDTH'(1) : b_mag;
    q_mag  = a_mag / b_safe;
    r_mag  = a_mag % b_safe;
    quo    = (a_neg ^ b_neg) ? -q_mag : q_mag;
    rem    = a_neg ? -r_mag : r_mag;

    hi_n = hi;
    lo_n = lo;
    if (is_div(op)) begin
      if (b == '0) begin
        hi_n = a;
        lo_n = '1;
      end else begin
        hi_n = rem;
        lo_n = quo;
      end
    end else if (is_acc(op)) begin
      {hi_n, lo_n} = acc;
    end else if (is_mult(op)) begin
      {hi_n, lo_n} = prod;
    end
  end

endmodule

// File: rtl/md_unit_param.sv
// Multi-cycle multiply/divide unit owning HI/LO, with accumulate modes,
// a done pulse and one-deep HI/LO rollback.
module md_unit_param
  import md_defs::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter bit EN_ACC      = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  input  logic             restore,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  localparam int MAX_LAT = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

  md_state_t        state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  md_op_t           op_t;
  logic             multi_op;
  logic             idle_issue;
  logic             accept_mc;
  logic             accept_mt;
  logic             commit;
  logic [WIDTH-1:0] hi_n, lo_n;
  logic [WIDTH-1:0] pend_hi, pend_lo;
  logic [WIDTH-1:0] snap_hi, snap_lo;

  assign op_t = md_op_t'(op);
  assign busy = (state == MD_RUN);

  md_arith #(.WIDTH(WIDTH)) u_arith (
    .op   (op_t),
    .a    (a),
    .b    (b),
    .hi   (hi),
    .lo   (lo),
    .hi_n (hi_n),
    .lo_n (lo_n)
  );

  // restore > cancel > commit > start; any abort also drops a same-cycle start.
  always_comb begin
    multi_op   = is_mult(op_t) | is_div(op_t) | (EN_ACC & is_acc(op_t));
    idle_issue = (state == MD_IDLE) & start & ~cancel & ~restore;
    accept_mc  = idle_issue & multi_op;
    accept_mt  = idle_issue & ((op_t == OP_MTHI) | (op_t == OP_MTLO));
    commit     = (state == MD_RUN) & (cnt == '0) & ~cancel & ~restore;
    state_n    = state;
    cnt_n      = cnt;
    if (restore | cancel) begin
      state_n = MD_IDLE;
      cnt_n   = '0;
    end else if (state == MD_RUN) begin
      if (cnt == '0) state_n = MD_IDLE;
      else           cnt_n   = cnt - CNT_W'(1);
    end else if (accept_mc) begin
      state_n = MD_RUN;
      cnt_n   = is_div(op_t) ? DIV_LOAD : MULT_LOAD;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= MD_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // The result is computed at accept from the accept-time HI/LO and held until commit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi      <= '0;
      lo      <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
      snap_hi <= '0;
      snap_lo <= '0;
      done    <= 1'b0;
    end else begin
      done <= commit;
      if (accept_mc) begin
        pend_hi <= hi_n;
        pend_lo <= lo_n;
        snap_hi <= hi;
        snap_lo <= lo;
      end
      if (accept_mt) begin
        snap_hi <= hi;
        snap_lo <= lo;
        if (op_t == OP_MTHI) hi <= a;
        else                 lo <= a;
      end
      if (restore) begin
        hi <= snap_hi;
        lo <= snap_lo;
      end else if (commit) begin
        hi <= pend_hi;
        lo <= pend_lo;
      end
    end
  end

endmodule

// File: tb/tb_md_unit_param.sv
// Self-checking bench for md_unit_param: directed vector table, hand-written
// cancel/restore/reset sequences and randomized ops against a reference model.
module tb_md_unit_param;
  import md_defs::*;

  localparam int W  = 32;
  localparam int ML = 5;
  localparam int DL = 10;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [3:0]   op;
  logic [W-1:0] a, b;
  logic         cancel, restore;
  logic [W-1:0] hi, lo;
  logic         busy, done;

  int vec_count   = 0;
  int miscompares = 0;

  logic [W-1:0]   m_hi   = '0;
  logic [W-1:0]   m_lo   = '0;
  logic [2*W-1:0] m_snap = '0;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[13];

  md_unit_param #(.WIDTH(W), .MULT_CYCLES(ML), .DIV_CYCLES(DL), .EN_ACC(1'b1)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .a       (a),
    .b       (b),
    .cancel  (cancel),
    .restore (restore),
    .hi      (hi),
    .lo      (lo),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    vec_count++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    @(negedge clk);
    start = 1'b0;
    op    = OP_NOP;
  endtask

  // Reference model: HI/LO as one 64-bit value, products and quotients by plain arithmetic.
  task automatic modelOp(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                         output logic [63:0] res, output int lat);
    logic [63:0] cur, sp, up;
    longint      lx, ly;
    int          sx, sy, q, r;
    cur = {m_hi, m_lo};
    sx  = x;
    sy  = y;
    lx  = sx;
    ly  = sy;
    sp  = lx * ly;
    up  = {32'b0, x} * {32'b0, y};
    res = cur;
    lat = 0;
    case (o)
      OP_MULT:  begin res = sp;       lat = ML; end
      OP_MULTU: begin res = up;       lat = ML; end
      OP_MADD:  begin res = cur + sp; lat = ML; end
      OP_MADDU: begin res = cur + up; lat = ML; end
      OP_MSUB:  begin res = cur - sp; lat = ML; end
      OP_MSUBU: begin res = cur - up; lat = ML; end
      OP_DIV: begin
        lat = DL;
        if (y == 32'd0) res = {x, 32'hFFFFFFFF};
        else if (x == 32'h80000000 && y == 32'hFFFFFFFF) res = {32'd0, x};
        else begin
          q   = sx / sy;
          r   = sx % sy;
          res = {r, q};
        end
      end
      OP_DIVU: begin
        lat = DL;
        if (y == 32'd0) res = {x, 32'hFFFFFFFF};
        else res = {x % y, x / y};
      end
      OP_MTHI: res = {x, m_lo};
      OP_MTLO: res = {m_hi, x};
      default: res = cur;
    endcase
    if (o != OP_NOP) m_snap = cur;
    {m_hi, m_lo} = res;
  endtask

  task automatic runOp(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic [63:0] exp, input int lat, input string name);
    int cycles;
    applyStimulus(o, x, y);
    cycles = 0;
    while (busy === 1'b1 && cycles < 200) begin
      cycles++;
      @(negedge clk);
    end
    checkOutput({name, " latency"}, 64'(cycles), 64'(lat));
    checkOutput({name, " done"}, {63'b0, done}, (lat != 0) ? 64'd1 : 64'd0);
    checkOutput({name, " hilo"}, {hi, lo}, exp);
    if (lat != 0) begin
      @(negedge clk);
      checkOutput({name, " done width"}, {63'b0, done}, 64'd0);
    end
  endtask

  task automatic modelRun(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                          input string name);
    logic [63:0] res;
    int          lat;
    modelOp(o, x, y, res, lat);
    runOp(o, x, y, res, lat, name);
  endtask

  function automatic logic [31:0] pickOperand();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hFFFFFFFF;
      2:       return 32'h80000000;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom();
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [3:0]  ops[10];
    logic [63:0] mres;
    int          mlat;
    int          cycles;
    logic        saw_done;

    vecs[0]  = '{OP_MULT,  32'hFFFFFFFD, 32'd7,        64'hFFFFFFFF_FFFFFFEB, ML};
    vecs[1]  = '{OP_DIV,   32'hFFFFFFF9, 32'd2,        64'hFFFFFFFF_FFFFFFFD, DL};
    vecs[2]  = '{OP_DIVU,  32'd7,        32'd0,        64'h00000007_FFFFFFFF, DL};
    vecs[3]  = '{OP_MTHI,  32'd0,        32'd0,        64'h00000000_FFFFFFFF, 0};
    vecs[4]  = '{OP_MTLO,  32'd5,        32'd0,        64'h00000000_00000005, 0};
    vecs[5]  = '{OP_MADDU, 32'd3,        32'd4,        64'h00000000_00000011, ML};
    vecs[6]  = '{OP_MSUB,  32'd1,        32'd18,       64'hFFFFFFFF_FFFFFFFF, ML};
    vecs[7]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, DL};
    vecs[8]  = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, ML};
    vecs[9]  = '{OP_DIV,   32'd7,        32'hFFFFFFFE, 64'h00000001_FFFFFFFD, DL};
    vecs[10] = '{OP_MADD,  32'hFFFFFFFF, 32'd2,        64'h00000001_FFFFFFFB, ML};
    vecs[11] = '{OP_MSUBU, 32'hFFFFFFFF, 32'd1,        64'h00000000_FFFFFFFC, ML};
    vecs[12] = '{OP_NOP,   32'd3,        32'd3,        64'h00000000_FFFFFFFC, 0};

    ops = '{OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU, OP_MTHI, OP_MTLO};

    reset   = 1'b0;
    start   = 1'b0;
    op      = OP_NOP;
    a       = '0;
    b       = '0;
    cancel  = 1'b0;
    restore = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset hilo", {hi, lo}, 64'd0);
    checkOutput("reset busy/done", {62'b0, busy, done}, 64'd0);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("post-reset busy/done", {62'b0, busy, done}, 64'd0);

    $display("[TB] directed vector table");
    for (int i = 0; i < 13; i++) begin
      modelOp(vecs[i].op, vecs[i].a, vecs[i].b, mres, mlat);
      runOp(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat, $sformatf("vec%0d", i));
      {m_hi, m_lo} = vecs[i].exp;
    end

    $display("[TB] cancel mid-flight");
    modelRun(OP_MTHI, 32'd1, 32'd0, "set hi");
    modelRun(OP_MTLO, 32'd2, 32'd0, "set lo");
    applyStimulus(OP_MULT, 32'd5, 32'd6);
    m_snap = {m_hi, m_lo};
    @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    checkOutput("cancel busy", {63'b0, busy}, 64'd0);
    saw_done = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (done === 1'b1) saw_done = 1'b1;
      @(negedge clk);
    end
    checkOutput("cancel no done", {63'b0, saw_done}, 64'd0);
    checkOutput("cancel hilo", {hi, lo}, {m_hi, m_lo});
    modelRun(OP_MULTU, 32'd2, 32'd3, "after cancel");

    $display("[TB] restore after MTLO");
    modelRun(OP_MTHI, 32'd1, 32'd0, "set hi");
    modelRun(OP_MTLO, 32'd2, 32'd0, "set lo");
    applyStimulus(OP_MTLO, 32'd9, 32'd0);
    checkOutput("mtlo write", {hi, lo}, {32'd1, 32'd9});
    restore = 1'b1;
    @(negedge clk);
    restore = 1'b0;
    checkOutput("mtlo restore", {hi, lo}, {32'd1, 32'd2});

    $display("[TB] restore coincident with commit");
    applyStimulus(OP_MULT, 32'd3, 32'd4);
    repeat (4) @(negedge clk);
    restore = 1'b1;
    @(negedge clk);
    restore = 1'b0;
    checkOutput("commit+restore hilo", {hi, lo}, {32'd1, 32'd2});
    checkOutput("commit+restore busy/done", {62'b0, busy, done}, 64'd0);
    @(negedge clk);
    checkOutput("commit+restore late done", {63'b0, done}, 64'd0);

    $display("[TB] start held during RUN");
    modelOp(OP_MULT, 32'd2, 32'd3, mres, mlat);
    @(negedge clk);
    start = 1'b1;
    op    = OP_MULT;
    a     = 32'd2;
    b     = 32'd3;
    @(negedge clk);
    op    = OP_DIV;
    a     = 32'd100;
    b     = 32'd7;
    cycles = 0;
    while (busy === 1'b1 && cycles < 200) begin
      cycles++;
      @(negedge clk);
    end
    start = 1'b0;
    op    = OP_NOP;
    checkOutput("held start latency", 64'(cycles), 64'(ML));
    checkOutput("held start hilo", {hi, lo}, mres);
    checkOutput("held start done", {63'b0, done}, 64'd1);
    @(negedge clk);
    checkOutput("held start idle", {62'b0, busy, done}, 64'd0);

    $display("[TB] async reset mid-RUN");
    applyStimulus(OP_DIV, 32'd100, 32'd7);
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("mid-run reset hilo", {hi, lo}, 64'd0);
    checkOutput("mid-run reset busy/done", {62'b0, busy, done}, 64'd0);
    @(negedge clk);
    reset  = 1'b1;
    m_hi   = '0;
    m_lo   = '0;
    m_snap = '0;

    $display("[TB] randomized ops");
    for (int i = 0; i < 40; i++) begin
      modelRun(ops[$urandom_range(0, 9)], pickOperand(), pickOperand(), $sformatf("rand%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule
